// File: rtl/id_pkg.sv
// Shared widths, stall-bus encoding, forwarding-bus field layout and interlock
// state type for the ID operand stage.
package id_pkg;

  localparam int unsigned STALL_BUS_W = 6;
  localparam int unsigned IF_TO_ID_WD = 33;
  localparam logic        STOP        = 1'b1;
  localparam logic        NO_STOP     = 1'b0;

  // Each forwarding source is packed as {we, waddr, wdata}, with wdata in the LSBs.
  function automatic int unsigned fwd_w(input int unsigned aw, input int unsigned dw);
    return 1 + aw + dw;
  endfunction

  function automatic int unsigned fwd_addr(input int unsigned dw);
    return dw;
  endfunction

  function automatic int unsigned fwd_we(input int unsigned aw, input int unsigned dw);
    return dw + aw;
  endfunction

  localparam int unsigned FWD_W    = fwd_w(5, 32);
  localparam int unsigned FWD_DATA = 0;
  localparam int unsigned FWD_ADDR = fwd_addr(32);
  localparam int unsigned FWD_WE   = fwd_we(5, 32);

  typedef enum logic {IDLE, STALL} id_state_e;

endpackage

// File: rtl/id_operand_stage_fwd_mux.sv
// Priority bypass for one source operand. Source 0 is youngest and wins;
// register 0 always reads as zero. hit flags any live writer of addr.
module fwd_mux
  import id_pkg::*;
#(
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned DATA_W  = 32,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic [REG_AW-1:0]                        addr,
  input  logic [NUM_FWD*fwd_w(REG_AW, DATA_W)-1:0] fwd_bus,
  input  logic [DATA_W-1:0]                        rf_rdata,
  output logic [DATA_W-1:0]                        data,
  output logic                                     hit
);

  localparam int unsigned FW = fwd_w(REG_AW, DATA_W);
  localparam int unsigned AO = fwd_addr(DATA_W);
  localparam int unsigned WO = fwd_we(REG_AW, DATA_W);

  logic [DATA_W-1:0] byp_data;

  always_comb begin
    hit      = 1'b0;
    byp_data = rf_rdata;
    // Scan oldest to youngest so the youngest matching source is applied last.
    for (int unsigned i = NUM_FWD; i > 0; i--) begin
      if (fwd_bus[(i-1)*FW + WO] && (fwd_bus[(i-1)*FW + AO +: REG_AW] == addr)) begin
        hit      = 1'b1;
        byp_data = fwd_bus[(i-1)*FW +: DATA_W];
      end
    end
    if (addr == '0) begin
      hit  = 1'b0;
      data = '0;
    end else if (BYPASS) begin
      data = byp_data;
    end else begin
      data = rf_rdata;
    end
  end

endmodule

// File: rtl/id_operand_stage.sv
// ID operand stage: IF->ID pipe register, stall hold of the SRAM word, operand
// bypass and load-use interlock. Optional feature macro: ID_FWD_EN.
module id_operand_stage
  import id_pkg::*;
#(
  parameter int unsigned NUM_FWD  = 3,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [STALL_BUS_W-1:0]                   stall,
  input  logic [IF_TO_ID_WD-1:0]                   if_to_id_bus,
  input  logic [31:0]                              inst_sram_rdata,
  input  logic                                     rs_used,
  input  logic                                     rt_used,
  input  logic                                     ex_is_load,
  input  logic [NUM_FWD*fwd_w(REG_AW, DATA_W)-1:0] fwd_bus,
  input  logic [DATA_W-1:0]                        rf_rdata1,
  input  logic [DATA_W-1:0]                        rf_rdata2,
  output logic [REG_AW-1:0]                        rf_raddr1,
  output logic [REG_AW-1:0]                        rf_raddr2,
  output logic                                     id_valid,
  output logic [31:0]                              id_pc,
  output logic [31:0]                              id_inst,
  output logic [DATA_W-1:0]                        src1,
  output logic [DATA_W-1:0]                        src2,
  output logic                                     stallreq_for_id
);

  logic        hold_v;
  logic [31:0] hold_inst;
  logic        hit1, hit2;
  logic        unused_in;

  assign unused_in = ^{stall[0], stall[STALL_BUS_W-1:3]};

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
    end else if (stall[1] == STOP && stall[2] == NO_STOP) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
    end else if (stall[1] == NO_STOP) begin
      id_valid <= if_to_id_bus[32];
      id_pc    <= if_to_id_bus[31:0];
    end
  end

  // SRAM data is only valid the cycle after fetch, so freeze it on stall entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v    <= 1'b0;
      hold_inst <= '0;
    end else if (stall[1] == STOP && !hold_v) begin
      hold_v    <= 1'b1;
      hold_inst <= inst_sram_rdata;
    end else if (stall[1] == NO_STOP) begin
      hold_v    <= 1'b0;
    end
  end

  assign id_inst   = hold_v ? hold_inst : inst_sram_rdata;
  assign rf_raddr1 = REG_AW'(id_inst[25:21]);
  assign rf_raddr2 = REG_AW'(id_inst[20:16]);

`ifdef ID_FWD_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  fwd_mux #(.NUM_FWD(NUM_FWD), .REG_AW(REG_AW), .DATA_W(DATA_W), .BYPASS(BYPASS)) u_fwd_rs (
    .addr(rf_raddr1), .fwd_bus(fwd_bus), .rf_rdata(rf_rdata1), .data(src1), .hit(hit1)
  );

  fwd_mux #(.NUM_FWD(NUM_FWD), .REG_AW(REG_AW), .DATA_W(DATA_W), .BYPASS(BYPASS)) u_fwd_rt (
    .addr(rf_raddr2), .fwd_bus(fwd_bus), .rf_rdata(rf_rdata2), .data(src2), .hit(hit2)
  );

`ifdef ID_FWD_EN
  localparam int unsigned AO = fwd_addr(DATA_W);
  localparam int unsigned WO = fwd_we(REG_AW, DATA_W);

  logic              fwd0_we;
  logic [REG_AW-1:0] fwd0_addr;
  logic              hz;
  id_state_e         state, state_n;
  logic [2:0]        cnt, cnt_n;
  logic              unused_hit;

  assign unused_hit = hit1 ^ hit2;
  assign fwd0_we    = fwd_bus[WO];
  assign fwd0_addr  = fwd_bus[AO +: REG_AW];
  assign hz = ex_is_load & fwd0_we &
              ((rs_used & (rf_raddr1 != '0) & (rf_raddr1 == fwd0_addr)) |
               (rt_used & (rf_raddr2 != '0) & (rf_raddr2 == fwd0_addr)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // The IDLE cycle that detects the hazard is the first stall cycle.
  always_comb begin
    state_n         = state;
    cnt_n           = cnt;
    stallreq_for_id = 1'b0;
    unique case (state)
      IDLE: begin
        stallreq_for_id = hz;
        if (hz && (LOAD_LAT > 1)) begin
          state_n = STALL;
          cnt_n   = 3'(LOAD_LAT - 2);
        end
      end
      STALL: begin
        stallreq_for_id = 1'b1;
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - 3'd1;
      end
    endcase
  end
`else
  logic unused_load;

  assign unused_load     = ex_is_load;
  assign stallreq_for_id = (rs_used & hit1) | (rt_used & hit2);
`endif

endmodule

// File: tb/tb_id_operand_stage.sv
// Scoreboard bench for id_operand_stage: driver queues expected outputs per
// cycle, monitor compares on the falling edge. Covers both ID_FWD_EN builds.
module tb_id_operand_stage;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned NF = 3;
  localparam int unsigned FW = 1 + AW + DW;

  logic              clk = 1'b0;
  logic              rst;
  logic [5:0]        stall;
  logic [32:0]       if_bus;
  logic [31:0]       sram;
  logic              rs_used, rt_used, ex_is_load;
  logic [NF*FW-1:0]  fwd_bus;
  logic [DW-1:0]     rf1, rf2;
  logic [AW-1:0]     raddr1, raddr2;
  logic              id_valid;
  logic [31:0]       id_pc, id_inst;
  logic [DW-1:0]     src1, src2;
  logic              stallreq;

  logic              fwe [NF];
  logic [AW-1:0]     fad [NF];
  logic [DW-1:0]     fdat[NF];

  always_comb begin
    fwd_bus = '0;
    for (int i = 0; i < NF; i++) fwd_bus[i*FW +: FW] = {fwe[i], fad[i], fdat[i]};
  end

  id_operand_stage #(.NUM_FWD(NF), .REG_AW(AW), .DATA_W(DW), .LOAD_LAT(3)) dut (
    .clk(clk), .rst(rst), .stall(stall), .if_to_id_bus(if_bus),
    .inst_sram_rdata(sram), .rs_used(rs_used), .rt_used(rt_used),
    .ex_is_load(ex_is_load), .fwd_bus(fwd_bus), .rf_rdata1(rf1), .rf_rdata2(rf2),
    .rf_raddr1(raddr1), .rf_raddr2(raddr2), .id_valid(id_valid), .id_pc(id_pc),
    .id_inst(id_inst), .src1(src1), .src2(src2), .stallreq_for_id(stallreq)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    string       name;
    logic        v;
    logic [31:0] pc, inst, s1, s2;
    logic        req;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [4:0] ea1, ea2;
      e   = q.pop_front();
      ea1 = e.inst[25:21];
      ea2 = e.inst[20:16];
      total++;
      if (e.cyc != cyc) begin
        bad++;
        $display("FAIL %s: sample missed, at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
      end else if (id_valid !== e.v || id_pc !== e.pc || id_inst !== e.inst ||
                   src1 !== e.s1 || src2 !== e.s2 || stallreq !== e.req ||
                   raddr1 !== ea1 || raddr2 !== ea2) begin
        bad++;
        $display("FAIL %s: got v=%b pc=%h inst=%h s1=%h s2=%h req=%b ra=%0d/%0d; want v=%b pc=%h inst=%h s1=%h s2=%h req=%b ra=%0d/%0d",
                 e.name, id_valid, id_pc, id_inst, src1, src2, stallreq, raddr1, raddr2,
                 e.v, e.pc, e.inst, e.s1, e.s2, e.req, ea1, ea2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string n, input logic v, input logic [31:0] pc,
                          input logic [31:0] inst, input logic [31:0] s1,
                          input logic [31:0] s2, input logic req);
    exp_t e;
    e.cyc = cyc; e.name = n; e.v = v; e.pc = pc; e.inst = inst;
    e.s1 = s1; e.s2 = s2; e.req = req;
    q.push_back(e);
  endtask

  task automatic setf(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    fwe[i] = we; fad[i] = a; fdat[i] = d;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {6'h23, rs, rt, imm};
  endfunction

  localparam logic [31:0] A = 32'hAAAA_0001;
  localparam logic [31:0] B = 32'hBBBB_0002;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end, at cycle %0d, required end before timeout", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; stall = '0; if_bus = '0; sram = '0;
    rs_used = 1'b0; rt_used = 1'b0; ex_is_load = 1'b0; rf1 = '0; rf2 = '0;
    for (int i = 0; i < NF; i++) setf(i, 1'b0, '0, '0);

    tick(); tick();
    push_exp("reset", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0; if_bus = {1'b1, 32'h100};

    tick();
    sram = mk(4, 6, 16'h1); rf1 = A; rf2 = B; rs_used = 1'b1; rt_used = 1'b1;
    push_exp("fetch", 1'b1, 32'h100, mk(4, 6, 16'h1), A, B, 1'b0);
    if_bus = {1'b1, 32'h104};

    tick();
    sram = mk(0, 7, 16'h2); setf(0, 1'b1, 5'd0, 32'hFFFF); ex_is_load = 1'b1;
    push_exp("reg0", 1'b1, 32'h104, mk(0, 7, 16'h2), 32'h0, B, 1'b0);
    if_bus = {1'b1, 32'h108};

    tick();
    ex_is_load = 1'b0; sram = mk(8, 9, 16'h3);
    setf(0, 1'b1, 5'd8, 32'h11); setf(2, 1'b1, 5'd8, 32'h33);
`ifdef ID_FWD_EN
    push_exp("prio_young", 1'b1, 32'h108, mk(8, 9, 16'h3), 32'h11, B, 1'b0);
`else
    push_exp("prio_young", 1'b1, 32'h108, mk(8, 9, 16'h3), A, B, 1'b1);
`endif
    if_bus = {1'b1, 32'h10C};

    tick();
    setf(0, 1'b0, 5'd8, 32'h11);
`ifdef ID_FWD_EN
    push_exp("prio_old", 1'b1, 32'h10C, mk(8, 9, 16'h3), 32'h33, B, 1'b0);
`else
    push_exp("prio_old", 1'b1, 32'h10C, mk(8, 9, 16'h3), A, B, 1'b1);
`endif
    if_bus = {1'b1, 32'h110};

    tick();
    sram = mk(8, 9, 16'h4); rs_used = 1'b0; rt_used = 1'b1;
`ifdef ID_FWD_EN
    push_exp("rs_unused", 1'b1, 32'h110, mk(8, 9, 16'h4), 32'h33, B, 1'b0);
`else
    push_exp("rs_unused", 1'b1, 32'h110, mk(8, 9, 16'h4), A, B, 1'b0);
`endif
    if_bus = {1'b1, 32'h114};

    tick();
    sram = mk(2, 8, 16'h5);
`ifdef ID_FWD_EN
    push_exp("rt_match", 1'b1, 32'h114, mk(2, 8, 16'h5), A, 32'h33, 1'b0);
`else
    push_exp("rt_match", 1'b1, 32'h114, mk(2, 8, 16'h5), A, B, 1'b1);
`endif
    if_bus = {1'b1, 32'h200};

    tick();
    for (int i = 0; i < NF; i++) setf(i, 1'b0, '0, '0);
    rs_used = 1'b0; rt_used = 1'b0; sram = mk(1, 2, 16'hA);
    push_exp("hold_a", 1'b1, 32'h200, mk(1, 2, 16'hA), A, B, 1'b0);
    stall = 6'b000110;

    tick();
    sram = mk(3, 4, 16'hB);
    push_exp("hold_b", 1'b1, 32'h200, mk(1, 2, 16'hA), A, B, 1'b0);
    stall = 6'b000010;

    tick();
    sram = mk(5, 6, 16'hC);
    push_exp("bubble", 1'b0, 32'h0, mk(1, 2, 16'hA), A, B, 1'b0);
    stall = 6'b000000; if_bus = {1'b1, 32'h300};

    tick();
    sram = mk(7, 1, 16'hD);
    push_exp("release", 1'b1, 32'h300, mk(7, 1, 16'hD), A, B, 1'b0);
    if_bus = {1'b1, 32'h304};

`ifdef ID_FWD_EN
    tick();
    sram = mk(5, 0, 16'h50); rs_used = 1'b1; ex_is_load = 1'b1;
    setf(0, 1'b1, 5'd5, 32'hDEAD); setf(1, 1'b1, 5'd5, 32'hBEEF);
    push_exp("lu_0", 1'b1, 32'h304, mk(5, 0, 16'h50), 32'hDEAD, 32'h0, 1'b1);
    stall = 6'b000111;

    tick();
    sram = mk(9, 9, 16'h99);
    push_exp("lu_1", 1'b1, 32'h304, mk(5, 0, 16'h50), 32'hDEAD, 32'h0, 1'b1);

    tick();
    sram = mk(9, 9, 16'h98);
    push_exp("lu_2", 1'b1, 32'h304, mk(5, 0, 16'h50), 32'hDEAD, 32'h0, 1'b1);

    tick();
    ex_is_load = 1'b0; setf(0, 1'b0, 5'd5, 32'hDEAD);
    push_exp("lu_done", 1'b1, 32'h304, mk(5, 0, 16'h50), 32'hBEEF, 32'h0, 1'b0);
    stall = 6'b000000; if_bus = {1'b1, 32'h308};

    tick();
    sram = mk(5, 0, 16'h0); setf(1, 1'b0, '0, '0);
    ex_is_load = 1'b1; setf(0, 1'b1, 5'd5, 32'hDEAD);
    push_exp("rst_stall0", 1'b1, 32'h308, mk(5, 0, 16'h0), 32'hDEAD, 32'h0, 1'b1);
    stall = 6'b000111;

    tick();
    rst = 1'b1;
    push_exp("rst_stall1", 1'b1, 32'h308, mk(5, 0, 16'h0), 32'hDEAD, 32'h0, 1'b1);

    tick();
    rst = 1'b0; ex_is_load = 1'b0; setf(0, 1'b0, '0, '0); sram = '0; rs_used = 1'b0;
    stall = 6'b000000;
    push_exp("rst_after", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
`else
    tick();
    sram = mk(3, 0, 16'h33); rs_used = 1'b1; rt_used = 1'b1; rf1 = 32'h1234;
    setf(2, 1'b1, 5'd3, 32'h77);
    push_exp("wb_hz", 1'b1, 32'h304, mk(3, 0, 16'h33), 32'h1234, 32'h0, 1'b1);
    stall = 6'b000111;

    tick();
    sram = mk(9, 9, 16'h9); setf(2, 1'b0, 5'd3, 32'h77); rf1 = 32'h77;
    push_exp("wb_after", 1'b1, 32'h304, mk(3, 0, 16'h33), 32'h77, 32'h0, 1'b0);
    stall = 6'b000000; if_bus = {1'b1, 32'h308};

    tick();
    push_exp("wb_resume", 1'b1, 32'h308, mk(9, 9, 16'h9), 32'h77, B, 1'b0);
`endif

    tick();
    sram = mk(4, 4, 16'hE); stall = 6'b000110;

    tick();
    rst = 1'b1; stall = '0; sram = '0; rs_used = 1'b0; rt_used = 1'b0;
    ex_is_load = 1'b0; rf1 = '0; rf2 = '0;
    for (int i = 0; i < NF; i++) setf(i, 1'b0, '0, '0);

    tick();
    rst = 1'b0;
    push_exp("reset_final", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

    tick(); tick();
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_operand_stage.md
# id_operand_stage

Parametrised decode-side operand stage for the SampleCPU 5-stage MIPS pipeline. It sits between IF and EX, next to the decoder and `regfile`. It registers the IF→ID bus and holds the instruction-SRAM word while ID is stalled. It resolves source operands through a priority bypass network over `NUM_FWD` producer buses, and runs a counter-based load-use interlock for configurable load latency.

## Interface
Parameters:
- `NUM_FWD`, 3: number of forwarding buses; index 0 is youngest (EX), highest priority.
- `REG_AW`, 5: register address width.
- `DATA_W`, 32: data width.
- `LOAD_LAT`, 1: stall cycles a load in EX imposes on a dependent consumer (1..7).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `stall` in `StallBus`: pipeline stall vector. `stall[1]` holds ID; `stall[2]` holds EX.
- `if_to_id_bus` in `IF_TO_ID_WD`: {ce, pc[31:0]}.
- `inst_sram_rdata` in 32: instruction SRAM read data, valid the cycle after fetch.
- `rs_used` in 1: decoder flag, the current instruction reads rs.
- `rt_used` in 1: decoder flag, the current instruction reads rt.
- `ex_is_load` in 1: the instruction in EX is a load.
- `fwd_bus` in `NUM_FWD*(1+REG_AW+DATA_W)`: packed {we, waddr, wdata} per source, source 0 in the LSBs.
- `rf_rdata1` in `DATA_W`: regfile read data, port 1.
- `rf_rdata2` in `DATA_W`: regfile read data, port 2.
- `rf_raddr1` out `REG_AW`: equals `inst[25:21]`.
- `rf_raddr2` out `REG_AW`: equals `inst[20:16]`.
- `id_valid` out 1: registered ce.
- `id_pc` out 32: registered pc.
- `id_inst` out 32: effective instruction.
- `src1` out `DATA_W`: resolved rs operand.
- `src2` out `DATA_W`: resolved rt operand.
- `stallreq_for_id` out 1: stall request to the stall controller.

## Operation
- **Pipe register**, in priority order:
  - `rst`: clear to 0.
  - `stall[1]`=Stop and `stall[2]`=NoStop: load 0 (bubble).
  - `stall[1]`=NoStop: load `if_to_id_bus`.
  - Otherwise: hold.
- **Hold register** (`hold_v`, `hold_inst`):
  - First cycle with `stall[1]`=Stop and `hold_v`=0: capture `inst_sram_rdata`, set `hold_v`.
  - `stall[1]`=NoStop: clear `hold_v`.
  - `id_inst` = `hold_v ? hold_inst : inst_sram_rdata`.
- **Bypass**, per operand with address `a`:
  - If `a`=0: result is 0.
  - Else the lowest-index source with `we`=1 and `waddr`=`a` supplies `wdata`.
  - If no source matches: use `rf_rdata`.
- **Load-use detection**: `hz` = `ex_is_load` & `fwd[0].we` & ((`rs_used` & rs≠0 & rs=`fwd[0].waddr`) | (`rt_used` & rt≠0 & rt=`fwd[0].waddr`)).
- **Interlock FSM**, states IDLE and STALL, 3-bit counter `cnt`:
  - IDLE: `stallreq_for_id` = `hz`. If `hz` and `LOAD_LAT`>1, go to STALL with `cnt` = `LOAD_LAT`-2.
  - STALL: `stallreq_for_id` = 1. If `cnt`=0, go to IDLE; else decrement `cnt`.
  - Total stall cycles = `LOAD_LAT`.
- **Reset**: clears the pipe register, `hold_v`, the FSM (to IDLE) and `cnt`, including when `rst` arrives mid-stall. All outputs read 0 the cycle after reset, since `inst_sram_rdata` is 0 at reset.

## Timing
- Pipe and hold registers update on the `clk` rising edge.
- `src1`, `src2`, `stallreq_for_id` and `rf_raddr*` are combinational from registered state plus same-cycle inputs; they add zero latency.
- A stall request raised in cycle N freezes ID at edge N+1. `id_inst` stays stable via the hold register for the whole stall.
- Simultaneous `hz` and `stall[1]` from another source: the FSM still advances. The hold register covers both causes.
- A match on several sources: the youngest wins. WB data never overrides EX data.

## Configuration
- `ID_FWD_EN` defined: bypass network and load-use FSM as described above.
- `ID_FWD_EN` undefined:
  - `src1`/`src2` come directly from `rf_rdata*` (register 0 still forced to 0).
  - The FSM is absent.
  - `stallreq_for_id` = 1 whenever any source with `we`=1 matches a used nonzero rs/rt.

## Structure
- Shared package `id_pkg`:
  - `FWD_W` = 1+`REG_AW`+`DATA_W`.
  - Field offsets `FWD_WE`, `FWD_ADDR`, `FWD_DATA`.
  - FSM state enum {IDLE, STALL}.
- Sub-module `fwd_mux`: one priority bypass per operand, instantiated twice.

## Test plan
- Reset mid-stall: `LOAD_LAT`=3, `hz`, `rst` in the 2nd stall cycle → next cycle `stallreq_for_id`=0, `id_pc`=0, FSM=IDLE.
- Forward priority: rs=8; src0={1,8,0x11}, src2={1,8,0x33} → `src1`=0x11; src0.we=0 → `src1`=0x33.
- Register 0: rs=0, src0={1,0,0xFFFF} → `src1`=0 and no stall.
- Load-use: `LOAD_LAT`=2, `lw` to r5 in EX, ID reads r5 → `stallreq_for_id` high exactly 2 cycles, `id_inst` unchanged while SRAM data changes.
- `stall[1]` stop with `stall[2]` go → `id_valid`=0 next cycle. On release, the held instruction is replaced by the new fetch.
- Build without `ID_FWD_EN`: WB writes r3, ID reads r3 → stall 1 cycle, then `src1`=`rf_rdata1`.
